// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the SRAM controller: FSM state encodings, beat count and wait-counter width.
package sram_ctrl_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_RD       = 3'd1;
  localparam state_t ST_WR_SETUP = 3'd2;
  localparam state_t ST_WR_PULSE = 3'd3;
  localparam state_t ST_WR_HOLD  = 3'd4;
  localparam state_t ST_ACK      = 3'd5;

  // Wide enough for a wait value of 15 cycles loaded as 14.
  localparam int WAIT_CW = 4;

  function automatic int calc_beats(input int dw);
    return 32 / dw;
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// Per-beat cycle counter: load a value, count down to zero, report zero.
module sram_wait_cnt
  import sram_ctrl_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [WAIT_CW-1:0] i_load_val,
  input  logic               i_dec,
  output logic               o_zero
);

  logic [WAIT_CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - WAIT_CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_zero = (cnt_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// 32-bit bus to asynchronous 8/16-bit SRAM bridge: splits each access into beats,
// paces reads and write strobes with a wait counter, and pulses o_ack when done.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int SRAM_DW = 16,
  parameter int SRAM_AW = 19,
  parameter int BUS_AW  = 21,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [BUS_AW-1:0]  i_addr,
  input  logic [3:0]         i_we,
  input  logic [31:0]        i_dat_w,
  input  logic               i_stb,
  output logic [31:0]        o_dat_r,
  output logic               o_ack,
  output logic [SRAM_AW-1:0] o_sram_a,
  inout  wire  [SRAM_DW-1:0] io_sram_d,
  output logic               o_sram_csn,
  output logic               o_sram_oen,
  output logic               o_sram_wen,
  output logic [1:0]         o_sram_ben
);

  localparam int BEATS = calc_beats(SRAM_DW);
  localparam int BW    = (BEATS > 2) ? 2 : 1;
  localparam int AW_HI = SRAM_AW - BW;
  localparam int LANES = SRAM_DW / 8;
  localparam logic [WAIT_CW-1:0] RD_LOAD = WAIT_CW'(RD_WAIT - 1);
  localparam logic [WAIT_CW-1:0] WR_LOAD = WAIT_CW'(WR_WAIT - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if (SRAM_DW != 8 && SRAM_DW != 16) begin : g_bad_dw
    $error("sram_ctrl: SRAM_DW must be 8 or 16");
  end
  if (RD_WAIT < 1 || RD_WAIT > 15) begin : g_bad_rd_wait
    $error("sram_ctrl: RD_WAIT must be in 1..15");
  end
  if (WR_WAIT < 1 || WR_WAIT > 15) begin : g_bad_wr_wait
    $error("sram_ctrl: WR_WAIT must be in 1..15");
  end
  if (AW_HI < 1 || AW_HI + 2 > BUS_AW) begin : g_bad_aw
    $error("sram_ctrl: SRAM_AW does not fit the bus address width");
  end

  state_t            state_q, state_d;
  logic [AW_HI-1:0]  addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [31:0]       dat_q, dat_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [31:0]       rd_buf_q, rd_buf_d;
  logic [31:0]       dat_r_q, dat_r_d;

  logic [BEATS-1:0]   en_in, en_q;
  logic [BW-1:0]      first_beat, next_beat;
  logic               has_next;
  logic [SRAM_DW-1:0] beat_wdat;
  logic [1:0]         beat_ben;
  logic               cnt_load, cnt_dec, cnt_zero;
  logic [WAIT_CW-1:0] cnt_val;
  logic               drive;
  logic               unused_addr;

  assign unused_addr = ^i_addr;

  sram_wait_cnt u_wait_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .i_dec      (cnt_dec),
    .o_zero     (cnt_zero)
  );

  // Beats with no byte enables are never visited, so the write path jumps between enabled beats.
  always_comb begin
    en_in      = '0;
    en_q       = '0;
    first_beat = '0;
    next_beat  = beat_q;
    has_next   = 1'b0;
    beat_wdat  = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      en_in[b] = |i_we[b*LANES +: LANES];
      en_q[b]  = |we_q[b*LANES +: LANES];
      if (en_in[b]) first_beat = BW'(b);
      if (en_q[b] && (b > int'(beat_q))) begin
        has_next  = 1'b1;
        next_beat = BW'(b);
      end
    end
    for (int b = 0; b < BEATS; b++) begin
      if (beat_q == BW'(b)) beat_wdat = dat_q[b*SRAM_DW +: SRAM_DW];
    end
  end

  if (SRAM_DW == 16) begin : g_ben16
    assign beat_ben = beat_q[0] ? ~we_q[3:2] : ~we_q[1:0];
  end else begin : g_ben8
    assign beat_ben = 2'b11;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    we_d     = we_q;
    dat_d    = dat_q;
    beat_d   = beat_q;
    rd_buf_d = rd_buf_q;
    dat_r_d  = dat_r_q;
    cnt_load = 1'b0;
    cnt_val  = RD_LOAD;
    cnt_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          addr_d = i_addr[AW_HI+1:2];
          we_d   = i_we;
          dat_d  = i_dat_w;
          if (i_we == 4'h0) begin
            state_d  = ST_RD;
            beat_d   = '0;
            cnt_load = 1'b1;
            cnt_val  = RD_LOAD;
          end else begin
            state_d = ST_WR_SETUP;
            beat_d  = first_beat;
          end
        end
      end
      ST_RD: begin
        if (cnt_zero) begin
          for (int b = 0; b < BEATS; b++) begin
            if (beat_q == BW'(b)) rd_buf_d[b*SRAM_DW +: SRAM_DW] = io_sram_d;
          end
          if (beat_q == LAST_BEAT) begin
            dat_r_d = rd_buf_d;
            state_d = ST_ACK;
          end else begin
            beat_d   = beat_q + BW'(1);
            cnt_load = 1'b1;
            cnt_val  = RD_LOAD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR_SETUP: begin
        state_d  = ST_WR_PULSE;
        cnt_load = 1'b1;
        cnt_val  = WR_LOAD;
      end
      ST_WR_PULSE: begin
        if (cnt_zero) state_d = ST_WR_HOLD;
        else          cnt_dec = 1'b1;
      end
      ST_WR_HOLD: begin
        if (has_next) begin
          state_d = ST_WR_SETUP;
          beat_d  = next_beat;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      we_q     <= '0;
      dat_q    <= '0;
      beat_q   <= '0;
      rd_buf_q <= '0;
      dat_r_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      dat_q    <= dat_d;
      beat_q   <= beat_d;
      rd_buf_q <= rd_buf_d;
      dat_r_q  <= dat_r_d;
    end
  end

  // SRAM strobes decode straight from the state flop so reset releases the bus immediately.
  assign drive      = (state_q == ST_WR_SETUP) || (state_q == ST_WR_PULSE) || (state_q == ST_WR_HOLD);
  assign io_sram_d  = drive ? beat_wdat : {SRAM_DW{1'bz}};
  assign o_sram_a   = {addr_q, beat_q};
  assign o_sram_csn = (state_q == ST_IDLE);
  assign o_sram_oen = (state_q != ST_RD);
  assign o_sram_wen = (state_q != ST_WR_PULSE);
  assign o_ack      = (state_q == ST_ACK);
  assign o_dat_r    = dat_r_q;

  always_comb begin
    o_sram_ben = 2'b11;
    if (drive) begin
      o_sram_ben = beat_ben;
    end else if ((state_q == ST_RD) && (SRAM_DW == 16)) begin
      o_sram_ben = 2'b00;
    end
  end

endmodule
